// File: rtl/one_wire_slave_if.sv
// Host-side byte interface of the 1-wire slave: transmit byte loading and
// receive byte / bus-reset notification.
interface one_wire_slave_if;
  // tx_load is a one-cycle strobe; it is accepted only while tx_ready=1 and the
  // slave is idle, otherwise dropped. rx_valid and reset_seen are one-cycle
  // pulses; rx_data holds its value until the next rx_valid.
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       reset_seen;

  modport slave (
    input  tx_data,
    input  tx_load,
    output tx_ready,
    output rx_data,
    output rx_valid,
    output reset_seen
  );

  modport master (
    output tx_data,
    output tx_load,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    input  reset_seen
  );
endinterface

// File: rtl/one_wire_slave.sv
// 1-wire bus slave: byte receive/transmit in master-timed slots, master reset
// detection and presence pulse generation. wire_out only ever pulls low.
module one_wire_slave #(
    parameter int CLK_MHZ = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wire_in,
    output wire               wire_out,
    one_wire_slave_if.slave   host,
    output logic [2:0]        dbg_state_o
);

    localparam logic [13:0] T_GLITCH = 14'(CLK_MHZ * 1);
    localparam logic [13:0] T_SAMP   = 14'(CLK_MHZ * 30);
    localparam logic [13:0] T_RST    = 14'(CLK_MHZ * 400);
    localparam logic [13:0] T_PDH    = 14'(CLK_MHZ * 30);
    localparam logic [13:0] T_PDL    = 14'(CLK_MHZ * 120);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SLOT       = 3'd1,
        WAIT_HIGH  = 3'd2,
        PRES_WAIT  = 3'd3,
        PRES_DRIVE = 3'd4
    } state_t;

    state_t      state_q;
    logic        sync1_q, sync2_q, prev_q;
    logic [13:0] cnt_q;
    logic        drive_q;
    logic        slot_tx_q;
    logic        rst_det_q;
    logic        tx_pend_q;
    logic [7:0]  tx_shift_q;
    logic [2:0]  tx_idx_q;
    logic [7:0]  rx_shift_q;
    logic [2:0]  rx_cnt_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        reset_seen_q;

    logic        fall;
    logic        load_ok;
    logic        tx_pend_d;
    logic        tx_bit_d;
    logic [13:0] cnt_d;
    logic [7:0]  rx_shift_d;

    always_comb begin
        fall       = prev_q & ~sync2_q;
        cnt_d      = (cnt_q == 14'h3FFF) ? cnt_q : cnt_q + 14'd1;
        load_ok    = host.tx_load & ~tx_pend_q & (state_q == IDLE);
        // A load landing on the same cycle as a falling edge still owns that slot.
        tx_pend_d  = tx_pend_q | load_ok;
        tx_bit_d   = load_ok ? host.tx_data[0] : tx_shift_q[tx_idx_q];
        rx_shift_d = {sync2_q, rx_shift_q[7:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            cnt_q        <= '0;
            drive_q      <= 1'b0;
            slot_tx_q    <= 1'b0;
            rst_det_q    <= 1'b0;
            tx_pend_q    <= 1'b0;
            tx_shift_q   <= '0;
            tx_idx_q     <= '0;
            rx_shift_q   <= '0;
            rx_cnt_q     <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            reset_seen_q <= 1'b0;
        end else begin
            sync1_q      <= wire_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            rx_valid_q   <= 1'b0;
            reset_seen_q <= 1'b0;

            if (load_ok) begin
                tx_pend_q  <= 1'b1;
                tx_shift_q <= host.tx_data;
                tx_idx_q   <= '0;
            end

            case (state_q)
                IDLE: begin
                    drive_q <= 1'b0;
                    if (fall) begin
                        state_q   <= SLOT;
                        cnt_q     <= '0;
                        slot_tx_q <= tx_pend_d;
                        drive_q   <= tx_pend_d & ~tx_bit_d;
                    end
                end

                SLOT: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == T_SAMP) begin
                        state_q <= WAIT_HIGH;
                        drive_q <= 1'b0;
                        if (slot_tx_q) begin
                            tx_idx_q <= tx_idx_q + 3'd1;
                            if (tx_idx_q == 3'd7) tx_pend_q <= 1'b0;
                        end else begin
                            rx_shift_q <= rx_shift_d;
                            rx_cnt_q   <= rx_cnt_q + 3'd1;
                            if (rx_cnt_q == 3'd7) begin
                                rx_data_q  <= rx_shift_d;
                                rx_valid_q <= 1'b1;
                            end
                        end
                    end else if (sync2_q && (cnt_q < T_GLITCH) && !drive_q) begin
                        // Too short to be a master slot: drop it without consuming a bit.
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == T_SAMP - 14'd1) begin
                        drive_q <= 1'b0;
                    end
                end

                WAIT_HIGH: begin
                    // Counter continues from the slot's falling edge, so a long
                    // low is timed from where it started.
                    cnt_q <= cnt_d;
                    if (sync2_q) begin
                        cnt_q     <= '0;
                        rst_det_q <= 1'b0;
                        state_q   <= rst_det_q ? PRES_WAIT : IDLE;
                    end else if ((cnt_q == T_RST) && !rst_det_q) begin
                        rst_det_q    <= 1'b1;
                        reset_seen_q <= 1'b1;
                        rx_cnt_q     <= '0;
                        tx_pend_q    <= 1'b0;
                        tx_idx_q     <= '0;
                    end
                end

                PRES_WAIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == T_PDH - 14'd1) begin
                        state_q <= PRES_DRIVE;
                        cnt_q   <= '0;
                        drive_q <= 1'b1;
                    end
                end

                PRES_DRIVE: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == T_PDL - 14'd1) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= '0;
                        drive_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

    assign wire_out        = drive_q ? 1'b0 : 1'bz;
    assign host.tx_ready   = ~tx_pend_q;
    assign host.rx_data    = rx_data_q;
    assign host.rx_valid   = rx_valid_q;
    assign host.reset_seen = reset_seen_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_one_wire_slave.sv
// Directed bench for one_wire_slave: a bus master model drives slots and reset
// pulses on a pulled-up bus while a scoreboard checks bytes, pulses and timing.
`timescale 1ns/100ps
module tb_one_wire_slave;
  localparam int US = 8;  // clock is 8 MHz here, so all limits scale by 8 per us
  localparam int T_RST = 400 * US;
  localparam int T_PDH = 30 * US;
  localparam int T_PDL = 120 * US;
  localparam int T_SAMP = 30 * US;

  logic clk = 1'b0;
  logic reset;
  logic master_low;
  wire wire_out_w;
  wire wire_in;
  logic [2:0] dbg_state;

  pullup pu_bus (wire_out_w);
  assign wire_in = master_low ? 1'b0 : wire_out_w;

  one_wire_slave_if host_if ();

  one_wire_slave #(.CLK_MHZ(US)) dut (
    .clk        (clk),
    .reset      (reset),
    .wire_in    (wire_in),
    .wire_out   (wire_out_w),
    .host       (host_if),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #62.5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rx_pulses = 0;
  int rst_pulses = 0;

  always @(negedge clk) begin
    if (host_if.rx_valid) rx_pulses <= rx_pulses + 1;
    if (host_if.reset_seen) rst_pulses <= rst_pulses + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_bit(input logic b);
    master_low = 1'b1;
    wait_cycles((b ? 10 : 100) * US);
    master_low = 1'b0;
    wait_cycles((b ? 92 : 2) * US);
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(output logic b, output int low_cnt);
    low_cnt = 0;
    b = 1'b1;
    master_low = 1'b1;
    for (int c = 0; c < 102 * US; c++) begin
      @(negedge clk);
      if (c == 10 * US - 1) master_low = 1'b0;
      if (c == 11 * US - 1) b = wire_in;
      if (wire_out_w == 1'b0) low_cnt++;
    end
  endtask

  // Holds the bus low for 480 us, then times the presence pulse.
  task automatic master_reset(output int t_seen, output int pres_wait, output int pres_low);
    int c;
    t_seen = -1;
    master_low = 1'b1;
    for (int i = 1; i <= 480 * US; i++) begin
      @(negedge clk);
      if (host_if.reset_seen && t_seen < 0) t_seen = i;
    end
    master_low = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (wire_out_w != 1'b0 && c < 2000);
    pres_wait = c - 1;
    pres_low = 1;
    while (pres_low < 4000) begin
      @(negedge clk);
      if (wire_out_w != 1'b0) break;
      pres_low++;
    end
  endtask

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] rd_byte;
  logic       rd_b;
  int         low_cnt;
  int         t_seen, pres_wait, pres_low;
  int         rx_before, rst_before;
  int         c;
  logic [7:0] tx_pat;

  initial begin
    reset = 1'b1;
    master_low = 1'b0;
    host_if.tx_data = 8'h00;
    host_if.tx_load = 1'b0;
    wait_cycles(5);
    check_eq("rst_wire_out", wire_out_w, 1'b1);
    check_eq("rst_tx_ready", host_if.tx_ready, 1'b1);
    check_eq("rst_rx_valid", host_if.rx_valid, 1'b0);
    check_eq("rst_reset_seen", host_if.reset_seen, 1'b0);
    check_eq("rst_rx_data", host_if.rx_data, 8'h00);
    check_eq("rst_state", dbg_state, 3'd0);
    reset = 1'b0;
    wait_cycles(20);

    // master reset and presence timing (window covers synchroniser latency)
    rst_before = rst_pulses;
    master_reset(t_seen, pres_wait, pres_low);
    check_eq("rst_seen_time_ok", (t_seen >= T_RST && t_seen <= T_RST + 6), 1'b1);
    check_eq("pres_wait_ok", (pres_wait >= T_PDH && pres_wait <= T_PDH + 6), 1'b1);
    check_eq("pres_low_len", pres_low, T_PDL);
    check_eq("pres_released", wire_out_w, 1'b1);
    wait_cycles(50);
    check_eq("rst_seen_pulses", rst_pulses - rst_before, 1);
    check_eq("post_pres_state", dbg_state, 3'd0);

    // master writes 0xA5
    exp_q.push_back(8'hA5);
    rx_before = rx_pulses;
    write_byte(8'hA5);
    wait_cycles(10);
    check_eq("wr_a5_rx_data", host_if.rx_data, exp_q.pop_front());
    check_eq("wr_a5_rx_pulses", rx_pulses - rx_before, 1);

    // load 0x3C, a second load while busy is dropped, master reads 8 slots
    tx_pat = 8'h3C;
    host_if.tx_data = tx_pat;
    host_if.tx_load = 1'b1;
    @(negedge clk);
    host_if.tx_load = 1'b0;
    check_eq("tx_ready_low", host_if.tx_ready, 1'b0);
    host_if.tx_data = 8'hFF;
    host_if.tx_load = 1'b1;
    @(negedge clk);
    host_if.tx_load = 1'b0;
    rx_before = rx_pulses;
    rd_byte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(rd_b, low_cnt);
      rd_byte[i] = rd_b;
      check_eq($sformatf("tx_slot%0d_low", i), low_cnt, tx_pat[i] ? 0 : T_SAMP);
    end
    check_eq("rd_byte", rd_byte, tx_pat);
    check_eq("tx_ready_back", host_if.tx_ready, 1'b1);
    check_eq("tx_no_rx_valid", rx_pulses - rx_before, 0);

    // 0.5 us glitch is discarded, then a clean byte
    master_low = 1'b1;
    wait_cycles(US / 2);
    master_low = 1'b0;
    wait_cycles(20);
    check_eq("glitch_state", dbg_state, 3'd0);
    exp_q.push_back(8'h69);
    rx_before = rx_pulses;
    write_byte(8'h69);
    wait_cycles(10);
    check_eq("glitch_rx_data", host_if.rx_data, exp_q.pop_front());
    check_eq("glitch_rx_pulses", rx_pulses - rx_before, 1);

    // three bits then a bus reset: partial byte is dropped
    rx_before = rx_pulses;
    rst_before = rst_pulses;
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    master_reset(t_seen, pres_wait, pres_low);
    check_eq("mid_rst_seen", (t_seen > 0), 1'b1);
    check_eq("mid_pres_low", pres_low, T_PDL);
    wait_cycles(50);
    check_eq("mid_rst_pulses", rst_pulses - rst_before, 1);
    check_eq("mid_rx_data_held", host_if.rx_data, 8'h69);
    exp_q.push_back(8'h5A);
    write_byte(8'h5A);
    wait_cycles(10);
    check_eq("after_rst_rx_data", host_if.rx_data, exp_q.pop_front());
    check_eq("after_rst_rx_pulses", rx_pulses - rx_before, 1);

    // pending tx discarded by bus reset, then block reset during presence drive
    host_if.tx_data = 8'hAA;
    host_if.tx_load = 1'b1;
    @(negedge clk);
    host_if.tx_load = 1'b0;
    check_eq("tx2_ready_low", host_if.tx_ready, 1'b0);
    master_low = 1'b1;
    wait_cycles(480 * US);
    check_eq("rst_drops_tx", host_if.tx_ready, 1'b1);
    master_low = 1'b0;
    c = 0;
    while (wire_out_w != 1'b0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check_eq("pres_drive_reached", dbg_state, 3'd4);
    wait_cycles(100);
    #7 reset = 1'b1;
    #1;
    check_eq("async_wire_out", wire_out_w, 1'b1);
    check_eq("async_tx_ready", host_if.tx_ready, 1'b1);
    check_eq("async_state", dbg_state, 3'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_cycles(US * 200);
    check_eq("post_async_wire_out", wire_out_w, 1'b1);
    check_eq("post_async_state", dbg_state, 3'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/one_wire_slave.md
ONE_WIRE_SLAVE -- requirements
Module: one_wire_slave

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 24, clk frequency in MHz; all timing constants are CLK_MHZ cycles per us.
REQ-002 SHALL have port clk  input  1  system clock, 24 MHz nominal.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high block reset.
REQ-004 SHALL have port wire_in  input  1  1-wire bus level, asynchronous.
REQ-005 SHALL have port wire_out  output  1  bus driver: 1'b0 pulls the bus low, 1'bZ releases it; never drives 1'b1.
REQ-006 SHALL have port tx_data  input  8  byte to send to the master, LSB first.
REQ-007 SHALL have port tx_load  input  1  one-cycle load strobe for tx_data.
REQ-008 SHALL have port tx_ready  output  1  high when no transmit byte is pending.
REQ-009 SHALL have port rx_data  output  8  last byte received from the master, LSB first.
REQ-010 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-011 SHALL have port reset_seen  output  1  one-cycle pulse when a master reset pulse is detected.

Function
REQ-012 SHALL synchronise wire_in through 2 flops; all timing is measured from the synchronised falling edge.
REQ-013 SHALL use one 14-bit counter, cleared on state entry, saturating at 16383.
REQ-014 SHALL use constants (cycles at 24 MHz): T_GLITCH=1us (24), T_SAMP=30us (720), T_RST=400us (9600), T_PDH=30us (720), T_PDL=120us (2880).
REQ-015 SHALL implement states IDLE, SLOT, WAIT_HIGH, PRES_WAIT, PRES_DRIVE.
REQ-016 IDLE: wire_out=Z; on synchronised falling edge -> SLOT.
REQ-017 SLOT, transmit slot (tx byte pending) with current tx bit 0: wire_out=0 from SLOT entry until counter==T_SAMP.
REQ-018 SLOT: if synchronised wire_in returns high before counter==T_GLITCH and the block is not driving, the event SHALL be discarded -> IDLE, no bit consumed.
REQ-019 SLOT: at counter==T_SAMP -> WAIT_HIGH with wire_out=Z; receive slot shifts synchronised wire_in into rx shifter; transmit slot advances tx bit index.
REQ-020 Receive: after 8th received bit, rx_data SHALL update and rx_valid SHALL pulse the following cycle; bit count returns to 0.
REQ-021 Transmit: tx_load while tx_ready=1 and state IDLE loads tx_data, clears tx_ready; the next 8 slots are transmit slots; tx_ready=1 after the 8th slot's T_SAMP; received-bit count unaffected, no rx_valid.
REQ-022 tx_load while tx_ready=0 or state!=IDLE SHALL be ignored.
REQ-023 WAIT_HIGH: counter keeps counting from falling edge; wire_in high -> IDLE; counter reaching T_RST while low -> reset detection.
REQ-024 Reset detection: reset_seen pulses one cycle; rx bit count cleared; pending tx byte discarded, tx_ready=1; rx_data held; then on wire_in high -> PRES_WAIT.
REQ-025 PRES_WAIT: wire_out=Z for T_PDH cycles -> PRES_DRIVE.
REQ-026 PRES_DRIVE: wire_out=0 for T_PDL cycles, then wire_out=Z -> WAIT_HIGH.
REQ-027 Simultaneous tx_load and reset detection: reset detection wins, load discarded.

Reset
REQ-028 On reset: state IDLE, wire_out=Z, tx_ready=1, rx_valid=0, reset_seen=0, rx_data=0, counter and bit counts 0, takes effect immediately (asynchronous), including mid-slot or mid-presence.

Verification
REQ-029 Master reset: wire low 480us -> reset_seen pulse 9600 cycles after sync edge; after release wire_out Z 720 cycles, 0 for 2880 cycles, then Z.
REQ-030 Master writes 0xA5 (1: 10us low, 0: 100us low, 102us slots) -> single rx_valid, rx_data=0xA5.
REQ-031 tx_load 0x3C, 8 master read slots (10us low, sample at 11us) -> wire_out=0 for 720 cycles in slots 0,1,6,7; master reads 0x3C; tx_ready returns 1; no rx_valid.
REQ-032 0.5us low glitch on wire_in -> no bit consumed, state IDLE; subsequent 8 write slots yield correct byte.
REQ-033 3 write bits then 480us low -> reset_seen, presence pulse; next 8 slots of 0x5A -> rx_data=0x5A.
REQ-034 Assert reset during PRES_DRIVE -> wire_out=Z same cycle, tx_ready=1, state IDLE.
